fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage sitting directly upstream of the single-cycle datapath. It owns the program counter and issues level-held requests to a variable-latency instruction memory. It registers the returned word and presents it, with its PC, to the datapath through a valid/ready handshake. It applies branch redirects (branch AND ALU zero flag) reported back by the datapath for the instruction currently presented, and optionally J-type jumps.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  fetch request; held high until acknowledged.
- imem_addr  out  32  word-aligned fetch address; equals the fetch PC whenever imem_req=1.
- imem_ack  in  1  imem_data is valid this cycle; the same cycle as the request is allowed.
- imem_data  in  32  fetched instruction word.
- instruccion  out  32  registered instruction to the datapath.
- pc_out  out  32  address of instruccion.
- pc_plus4  out  32  pc_out + 4, modulo 2^32.
- inst_valid  out  1  instruccion/pc_out are valid.
- inst_ready  in  1  datapath consumes the instruction this cycle.
- br_taken  in  1  branch AND zero flag for the presented instruction.
- br_offset  in  32  sign-extended immediate, in words.
- jump  in  1  J-type jump for the presented instruction; honoured only with FETCH_JUMP_EN.
- jump_index  in  26  instruction[25:0] of the jump.
- inst_count  out  32  number of instructions accepted by the datapath; wraps at 2^32.

## Operation
- Two-state FSM:
  - FETCH: imem_req=1 and imem_addr=pc_fetch.
  - HOLD: imem_req=0 and inst_valid=1.
- Transition FETCH→HOLD when imem_ack=1:
  - imem_data is captured into instruccion.
  - pc_fetch is captured into pc_out.
  - inst_valid is set.
- While in FETCH with imem_ack=0, the state is held and imem_req stays high with a stable address.
- Transition HOLD→FETCH when inst_ready=1. Accept = inst_valid AND inst_ready.
  - pc_fetch is loaded with next_pc.
  - inst_valid clears.
  - inst_count increments.
- next_pc priority:
  1. jump (macro enabled): {pc_plus4[31:28], jump_index, 2'b00}.
  2. br_taken: pc_plus4 + (br_offset << 2), 32-bit, overflow discarded.
  3. Otherwise: pc_plus4.
- br_taken and jump are ignored in any cycle without an accept.
- imem_ack is ignored outside FETCH.
- instruccion and pc_out are stable throughout HOLD.
- PC wrap-around: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag raised.

## Timing
- Reset values:
  - state = FETCH; pc_fetch = RESET_PC.
  - instruccion = 0, pc_out = 0, pc_plus4 = 4 (derived from pc_out), inst_valid = 0, inst_count = 0.
  - imem_req = 0 and imem_addr = RESET_PC while rst is high.
- First cycle after rst deasserts: imem_req=1 with imem_addr=RESET_PC.
- Fetch latency: with an ack in the request cycle N, inst_valid=1 in cycle N+1.
- Throughput: with zero-wait memory and inst_ready held at 1, one instruction every 2 cycles. An accept in cycle N gives a new request in N+1.
- Redirect takes effect in the request immediately after the accept. No wrong-path fetch is ever issued.
- rst mid-fetch: the outstanding request is abandoned. The memory must not return an ack for it after reset, and any ack seen during rst is ignored.
- rst overrides a simultaneous accept or ack.

## Configuration
- FETCH_JUMP_EN:
  - Defined: the jump port is honoured, with priority over br_taken.
  - Undefined: the jump and jump_index ports remain present but are unused, and next_pc covers only the branch or sequential case.

## Structure
- Shared package mips_pkg contains:
  - the fetch FSM state typedef (FETCH, HOLD);
  - RESET_PC default constant;
  - the PC increment constant 4;
  - opcode constants OP_RTYPE=6'b000000, OP_BEQ=6'b000100, OP_J=6'b000010.
- One sub-module: pc_next_calc, combinational. Inputs are pc_plus4, br_taken, br_offset, jump, jump_index; the output is next_pc. The macro is evaluated inside it.

## Test plan
- Reset, zero-wait memory, inst_ready=1: requests at 0x0, 0x4, 0x8; inst_valid pulses every 2nd cycle; inst_count=3 after the third accept.
- Memory acks 3 cycles late: imem_addr holds 0x4 for 3 cycles; a late ack while in HOLD is ignored; instruccion is unchanged until inst_ready.
- Accept at pc_out=0x10 with br_taken=1, br_offset=32'hFFFF_FFFC: next request goes to 0x4. With br_taken=1 but inst_ready=0, no redirect occurs and the state stays HOLD.
- Macro on, accept at pc_out=0x1000_0008 with jump=1, jump_index=26'h40, br_taken=1: next request goes to 0x1000_0100. Macro off: next request goes to 0x1000_000C plus the branch offset.
- Wrap-around: RESET_PC=32'hFFFF_FFFC, sequential accept → next request at 0x0.
- rst asserted while in FETCH with ack pending: outputs return to their reset values; the first post-reset request goes to RESET_PC; inst_count=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end: fetch FSM states,
// reset PC default, PC increment and the primary opcode values.
// No logic; imported by fetch_stage and the bench.
package mips_pkg;

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_INC           = 32'd4;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/pc_next_calc.sv
// Next fetch address: J-type jump (only when FETCH_JUMP_EN is defined),
// else taken branch, else sequential pc_plus4.
// Purely combinational; no latency, no backpressure.
module pc_next_calc (
   input  logic [31:0] pc_plus4,
   input  logic        br_taken,
   input  logic [31:0] br_offset,
   input  logic        jump,
   input  logic [25:0] jump_index,
   output logic [31:0] next_pc
);

`ifdef FETCH_JUMP_EN
   // Jump beats branch, branch beats sequential; the offset is in words.
   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = {pc_plus4[31:28], jump_index, 2'b00};
      end else if (br_taken) begin
         next_pc = pc_plus4 + (br_offset << 2);
      end
   end
`else
   // Jump ports stay on the interface but play no part in this build.
   logic unused_jump;
   assign unused_jump = jump ^ (^jump_index);

   // Branch target when taken, otherwise fall through.
   always_comb begin
      next_pc = pc_plus4;
      if (br_taken) begin
         next_pc = pc_plus4 + (br_offset << 2);
      end
   end
`endif

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues level-held imem requests, registers
// the returned word. Latency: ack in cycle N -> inst_valid in N+1.
// Backpressure: holds instruction (HOLD) until inst_ready; one word in flight.
// Optional J-type jumps are compiled in with the FETCH_JUMP_EN macro.
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   output logic [31:0] instruccion,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic        br_taken,
   input  logic [31:0] br_offset,
   input  logic        jump,
   input  logic [25:0] jump_index,
   output logic [31:0] inst_count
);

   fetch_state_e state_q;
   logic [31:0]  pc_fetch_q;
   logic [31:0]  instr_q;
   logic [31:0]  pc_out_q;
   logic         valid_q;
   logic [31:0]  count_q;
   logic [31:0]  next_pc_d;

   // Redirect target for the instruction currently presented.
   pc_next_calc u_pc_next_calc (
      .pc_plus4   (pc_plus4),
      .br_taken   (br_taken),
      .br_offset  (br_offset),
      .jump       (jump),
      .jump_index (jump_index),
      .next_pc    (next_pc_d)
   );

   // Request is a function of state; reset forces it low and parks the
   // address at RESET_PC so nothing stale is seen on the bus during reset.
   always_comb begin
      imem_req  = (state_q == FETCH) && !rst;
      imem_addr = rst ? RESET_PC : pc_fetch_q;
   end

   assign instruccion = instr_q;
   assign pc_out      = pc_out_q;
   assign pc_plus4    = pc_out_q + PC_INC;
   assign inst_valid  = valid_q;
   assign inst_count  = count_q;

   // Fetch FSM: capture on ack in FETCH, release and redirect on accept in
   // HOLD. Ack is only looked at in FETCH, redirects only on an accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FETCH;
         pc_fetch_q <= RESET_PC;
         instr_q    <= 32'h0;
         pc_out_q   <= 32'h0;
         valid_q    <= 1'b0;
         count_q    <= 32'h0;
      end else begin
         case (state_q)
            FETCH: begin
               if (imem_ack) begin
                  instr_q  <= imem_data;
                  pc_out_q <= pc_fetch_q;
                  valid_q  <= 1'b1;
                  state_q  <= HOLD;
               end
            end
            HOLD: begin
               if (inst_ready) begin
                  pc_fetch_q <= next_pc_d;
                  valid_q    <= 1'b0;
                  count_q    <= count_q + 32'd1;
                  state_q    <= FETCH;
               end
            end
            default: begin
               state_q <= FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences for the
// multi-cycle corners, then randomized traffic against a transaction model.
// A second instance with RESET_PC=0xFFFF_FFFC covers PC wrap-around.
module tb_fetch_stage;
   import mips_pkg::*;

`ifdef FETCH_JUMP_EN
   localparam bit JUMP_EN = 1'b1;
`else
   localparam bit JUMP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req, imem_ack, inst_valid, inst_ready, br_taken, jump;
   logic [31:0] imem_addr, imem_data, instruccion, pc_out, pc_plus4;
   logic [31:0] br_offset, inst_count;
   logic [25:0] jump_index;

   logic        w_req, w_ack, w_valid, w_ready;
   logic [31:0] w_addr, w_data, w_instr, w_pc_out, w_pc_plus4, w_count;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data), .instruccion(instruccion),
      .pc_out(pc_out), .pc_plus4(pc_plus4), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .br_taken(br_taken), .br_offset(br_offset),
      .jump(jump), .jump_index(jump_index), .inst_count(inst_count)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
      .imem_ack(w_ack), .imem_data(w_data), .instruccion(w_instr),
      .pc_out(w_pc_out), .pc_plus4(w_pc_plus4), .inst_valid(w_valid),
      .inst_ready(w_ready), .br_taken(1'b0), .br_offset(32'h0),
      .jump(1'b0), .jump_index(26'h0), .inst_count(w_count)
   );

   int n_vec  = 0;
   int n_fail = 0;

   // Transaction model: what is presented and where the next fetch goes.
   bit          m_valid;
   logic [31:0] m_pc, m_inst, m_fpc, m_cnt;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      logic [5:0] op;
      op = (a[3:2] == 2'd1) ? OP_BEQ : ((a[3:2] == 2'd2) ? OP_J : OP_RTYPE);
      return {op, 26'h0} ^ (a * 32'h0000_9E37);
   endfunction

   function automatic logic [31:0] ref_next(input logic [31:0] pc, input bit b,
                                            input logic [31:0] off, input bit j,
                                            input logic [25:0] ji);
      logic [31:0] p4;
      p4 = pc + 32'd4;
      if (JUMP_EN && j) return (p4 & 32'hF000_0000) | ({6'd0, ji} * 32'd4);
      if (b)            return p4 + off * 32'd4;
      return p4;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: drive, check pre-edge outputs against the model, advance.
   task automatic cycle(input bit r, input bit a, input bit rd, input bit b,
                        input logic [31:0] o, input bit j, input logic [25:0] ji);
      rst = r; imem_ack = a; inst_ready = rd; br_taken = b;
      br_offset = o; jump = j; jump_index = ji;
      imem_data = m_valid ? $urandom : word_at(m_fpc);
      w_data = word_at(w_addr);
      #1;
      chk("imem_req", {31'd0, imem_req}, {31'd0, !r && !m_valid});
      if (r || !m_valid) chk("imem_addr", imem_addr, r ? 32'h0 : m_fpc);
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
      chk("instruccion", instruccion, m_inst);
      chk("pc_out", pc_out, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("inst_count", inst_count, m_cnt);
      if (r) begin
         m_valid = 0; m_pc = 0; m_inst = 0; m_fpc = 0; m_cnt = 0;
      end else if (!m_valid) begin
         if (a) begin m_valid = 1; m_pc = m_fpc; m_inst = imem_data; end
      end else if (rd) begin
         m_fpc = ref_next(m_pc, b, o, j, ji);
         m_valid = 0;
         m_cnt = m_cnt + 1;
      end
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          ack, rdy, br;
      logic [31:0] off;
      bit          jmp;
      logic [25:0] jidx;
      bit          e_req;
      logic [31:0] e_addr;
      bit          e_vld;
      logic [31:0] e_pco, e_cnt;
   } vec_t;

   vec_t tbl[19];

   initial begin
      logic [31:0] x, exp_tgt;
      rst = 1; imem_ack = 0; inst_ready = 0; br_taken = 0; br_offset = 0;
      jump = 0; jump_index = 0; imem_data = 0; w_ack = 0; w_ready = 0; w_data = 0;
      m_valid = 0; m_pc = 0; m_inst = 0; m_fpc = 0; m_cnt = 0;

      //          ack rdy br off           jmp jidx    req addr   vld pco   cnt
      tbl[0]  = '{1, 1, 0, 32'h0,        0, 26'h0,  1, 32'h0,  0, 32'h0,  0};
      tbl[1]  = '{0, 1, 0, 32'h0,        0, 26'h0,  0, 32'h0,  1, 32'h0,  0};
      tbl[2]  = '{1, 1, 0, 32'h0,        0, 26'h0,  1, 32'h4,  0, 32'h0,  1};
      tbl[3]  = '{0, 1, 0, 32'h0,        0, 26'h0,  0, 32'h0,  1, 32'h4,  1};
      tbl[4]  = '{1, 1, 0, 32'h0,        0, 26'h0,  1, 32'h8,  0, 32'h4,  2};
      tbl[5]  = '{0, 1, 0, 32'h0,        0, 26'h0,  0, 32'h0,  1, 32'h8,  2};
      tbl[6]  = '{1, 0, 0, 32'h0,        0, 26'h0,  1, 32'hC,  0, 32'h8,  3};
      tbl[7]  = '{0, 0, 1, 32'hFFFFFFFF, 0, 26'h0,  0, 32'h0,  1, 32'hC,  3};
      tbl[8]  = '{1, 0, 0, 32'h0,        0, 26'h0,  0, 32'h0,  1, 32'hC,  3};
      tbl[9]  = '{0, 1, 0, 32'h0,        0, 26'h0,  0, 32'h0,  1, 32'hC,  3};
      tbl[10] = '{1, 1, 0, 32'h0,        0, 26'h0,  1, 32'h10, 0, 32'hC,  4};
      tbl[11] = '{0, 1, 1, 32'hFFFFFFFC, 0, 26'h0,  0, 32'h0,  1, 32'h10, 4};
      tbl[12] = '{0, 1, 0, 32'h0,        0, 26'h0,  1, 32'h4,  0, 32'h10, 5};
      tbl[13] = '{0, 1, 0, 32'h0,        0, 26'h0,  1, 32'h4,  0, 32'h10, 5};
      tbl[14] = '{0, 1, 0, 32'h0,        0, 26'h0,  1, 32'h4,  0, 32'h10, 5};
      tbl[15] = '{1, 0, 0, 32'h0,        0, 26'h0,  1, 32'h4,  0, 32'h10, 5};
      tbl[16] = '{0, 0, 0, 32'h0,        0, 26'h0,  0, 32'h0,  1, 32'h4,  5};
      tbl[17] = '{1, 0, 0, 32'h0,        0, 26'h0,  0, 32'h0,  1, 32'h4,  5};
      tbl[18] = '{0, 1, 1, 32'h2,        1, 26'h40, 0, 32'h0,  1, 32'h4,  5};

      @(posedge clk); #1;
      // Reset values while rst is held.
      cycle(1, 1, 1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 19; i++) begin
         rst = 0; imem_ack = tbl[i].ack; inst_ready = tbl[i].rdy;
         #0;
         chk($sformatf("tbl%0d.req", i), {31'd0, imem_req}, {31'd0, tbl[i].e_req});
         if (tbl[i].e_req) chk($sformatf("tbl%0d.addr", i), imem_addr, tbl[i].e_addr);
         chk($sformatf("tbl%0d.vld", i), {31'd0, inst_valid}, {31'd0, tbl[i].e_vld});
         chk($sformatf("tbl%0d.pco", i), pc_out, tbl[i].e_pco);
         chk($sformatf("tbl%0d.cnt", i), inst_count, tbl[i].e_cnt);
         cycle(0, tbl[i].ack, tbl[i].rdy, tbl[i].br, tbl[i].off, tbl[i].jmp, tbl[i].jidx);
      end
      chk("redir_jump_vs_branch", imem_addr, JUMP_EN ? 32'h0000_0100 : 32'h0000_0010);
      chk("count_after_redir", inst_count, 32'd6);

      // Branch to 0x1000_0008, then jump with a simultaneous branch.
      x = imem_addr;
      cycle(0, 1, 0, 0, 0, 0, 0);
      cycle(0, 0, 1, 1, (32'h1000_0008 - (x + 32'd4)) >> 2, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0);
      chk("at_1000_0008", pc_out, 32'h1000_0008);
      cycle(0, 0, 1, 1, 32'h1, 1, 26'h40);
      exp_tgt = JUMP_EN ? 32'h1000_0100 : 32'h1000_0010;
      chk("jump_target", imem_addr, exp_tgt);

      // Reset in FETCH with an ack arriving during reset.
      cycle(1, 1, 1, 0, 0, 0, 0);
      cycle(1, 1, 1, 0, 0, 0, 0);
      chk("rst_count", inst_count, 32'd0);
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      rst = 0; imem_ack = 0; #0;
      chk("post_rst_addr", imem_addr, 32'h0);
      chk("post_rst_req", {31'd0, imem_req}, 32'd1);

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] o;
         o = $urandom_range(0, 15) - 32'd8;
         cycle(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
               $urandom_range(0, 4) < 3, $urandom_range(0, 2) == 0, o,
               $urandom_range(0, 3) == 0, 26'($urandom));
      end

      // Wrap-around on the second instance.
      cycle(1, 0, 0, 0, 0, 0, 0);
      rst = 0; #1;
      chk("w_req", {31'd0, w_req}, 32'd1);
      chk("w_addr", w_addr, 32'hFFFF_FFFC);
      w_ack = 1;
      cycle(0, 0, 0, 0, 0, 0, 0);
      w_ack = 0;
      chk("w_valid", {31'd0, w_valid}, 32'd1);
      chk("w_instr", w_instr, word_at(32'hFFFF_FFFC));
      chk("w_pc_out", w_pc_out, 32'hFFFF_FFFC);
      chk("w_pc_plus4", w_pc_plus4, 32'h0);
      w_ready = 1;
      cycle(0, 0, 0, 0, 0, 0, 0);
      w_ready = 0;
      chk("w_wrap_addr", w_addr, 32'h0);
      chk("w_wrap_req", {31'd0, w_req}, 32'd1);
      chk("w_count", w_count, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
